// File: rtl/call_controller.sv
// Call controller: UI commands and network messages drive
// a five-state call FSM that owns a one-deep transmit slot.
module call_controller #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  input  logic [7:0] cmd_addr,
  output logic       cmd_ready,
  output logic       net_tx_valid,
  input  logic       net_tx_ready,
  output logic [2:0] net_tx_type,
  output logic [7:0] net_tx_addr,
  input  logic       net_rx_valid,
  input  logic [2:0] net_rx_type,
  input  logic [7:0] net_rx_addr,
  output logic       incoming_call,
  output logic [7:0] inc_address,
  output logic [2:0] call_state,
  output logic       audio_en,
  output logic       err
);

  localparam int TW =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int RW =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT_CYC);
  localparam logic [RW-1:0] MAXR  = RW'(MAX_RETRY);

  localparam logic [2:0] M_INIT   = 3'd0;
  localparam logic [2:0] M_REQ    = 3'd1;
  localparam logic [2:0] M_ACK    = 3'd2;
  localparam logic [2:0] M_REJ    = 3'd3;
  localparam logic [2:0] M_HANGUP = 3'd4;

  localparam logic [2:0] C_INIT   = 3'd0;
  localparam logic [2:0] C_CALL   = 3'd1;
  localparam logic [2:0] C_ACCEPT = 3'd2;
  localparam logic [2:0] C_REJECT = 3'd3;
  localparam logic [2:0] C_END    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INCOMING = 3'd1,
    S_OUTGOING = 3'd2,
    S_BUSY     = 3'd3,
    S_INIT     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          tx_valid_q, tx_valid_d;
  logic [2:0]    tx_type_q, tx_type_d;
  logic [7:0]    tx_addr_q, tx_addr_d;
  logic [7:0]    peer_q, peer_d;
  logic [7:0]    inc_q, inc_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          sent_q, sent_d;
  logic          err_q, err_d;
  logic          icall_q, icall_d;
  logic          audio_q, audio_d;

  logic tx_xfer;
  logic cmd_go;
  logic rx_peer;
  logic in_call;
  logic auto_rej;
  logic req_done;

  assign tx_xfer  = tx_valid_q & net_tx_ready;
  assign cmd_go   = cmd_valid & cmd_ready;
  assign rx_peer  = net_rx_valid & (net_rx_addr == peer_q);
  assign in_call  = (state_q == S_INCOMING) |
                    (state_q == S_OUTGOING) |
                    (state_q == S_BUSY);
  // a stranger calling while we are engaged gets a REJ
  // only if the tx slot is free right now
  assign auto_rej = net_rx_valid & in_call &
                    (net_rx_type == M_REQ) &
                    (net_rx_addr != peer_q) &
                    ~tx_valid_q;
  // the timeout only runs once the CALL_REQ has left
  assign req_done = sent_q |
                    (tx_xfer & (tx_type_q == M_REQ));

  assign cmd_ready     = ~tx_valid_q & ~net_rx_valid;
  assign net_tx_valid  = tx_valid_q;
  assign net_tx_type   = tx_type_q;
  assign net_tx_addr   = tx_addr_q;
  assign incoming_call = icall_q;
  assign inc_address   = inc_q;
  assign call_state    = state_q;
  assign audio_en      = audio_q;
  assign err           = err_q;

  // next-state, tx slot, timer and retry bookkeeping
  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_type_d  = tx_type_q;
    tx_addr_d  = tx_addr_q;
    peer_d     = peer_q;
    inc_d      = inc_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    sent_d     = sent_q;
    err_d      = 1'b0;

    if (tx_xfer) begin
      tx_valid_d = 1'b0;
      if (tx_type_q == M_REQ)
        sent_d = 1'b1;
    end

    if (auto_rej) begin
      tx_valid_d = 1'b1;
      tx_type_d  = M_REJ;
      tx_addr_d  = net_rx_addr;
    end

    unique case (state_q)
      S_INIT: begin
        if (net_rx_valid && net_rx_type == M_INIT) begin
          state_d = S_IDLE;
        end else if (cmd_go && cmd == C_INIT) begin
          tx_valid_d = 1'b1;
          tx_type_d  = M_INIT;
          tx_addr_d  = cmd_addr;
        end
      end
      S_IDLE: begin
        if (net_rx_valid && net_rx_type == M_REQ) begin
          peer_d  = net_rx_addr;
          inc_d   = net_rx_addr;
          state_d = S_INCOMING;
        end else if (cmd_go && cmd == C_CALL) begin
          peer_d     = cmd_addr;
          tx_valid_d = 1'b1;
          tx_type_d  = M_REQ;
          tx_addr_d  = cmd_addr;
          retry_d    = '0;
          timer_d    = TLOAD;
          sent_d     = 1'b0;
          state_d    = S_OUTGOING;
        end
      end
      S_INCOMING: begin
        if (rx_peer && net_rx_type == M_HANGUP) begin
          state_d = S_IDLE;
        end else if (cmd_go && cmd == C_ACCEPT) begin
          tx_valid_d = 1'b1;
          tx_type_d  = M_ACK;
          tx_addr_d  = peer_q;
          state_d    = S_BUSY;
        end else if (cmd_go && cmd == C_REJECT) begin
          tx_valid_d = 1'b1;
          tx_type_d  = M_REJ;
          tx_addr_d  = peer_q;
          state_d    = S_IDLE;
        end
      end
      S_OUTGOING: begin
        if (rx_peer && net_rx_type == M_ACK) begin
          state_d = S_BUSY;
        end else if (rx_peer && net_rx_type == M_REJ) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (cmd_go && cmd == C_END) begin
          tx_valid_d = 1'b1;
          tx_type_d  = M_HANGUP;
          tx_addr_d  = peer_q;
          state_d    = S_IDLE;
        end else if (req_done) begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else if (retry_q < MAXR) begin
            // resend waits at zero until the slot is free
            if (!tx_valid_q && !auto_rej) begin
              tx_valid_d = 1'b1;
              tx_type_d  = M_REQ;
              tx_addr_d  = peer_q;
              retry_d    = retry_q + RW'(1);
              timer_d    = TLOAD;
              sent_d     = 1'b0;
            end
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (rx_peer && net_rx_type == M_HANGUP) begin
          state_d = S_IDLE;
        end else if (cmd_go && cmd == C_END) begin
          tx_valid_d = 1'b1;
          tx_type_d  = M_HANGUP;
          tx_addr_d  = peer_q;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    icall_d = (state_d == S_INCOMING);
    audio_d = (state_d == S_BUSY);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      tx_valid_q <= 1'b0;
      tx_type_q  <= '0;
      tx_addr_q  <= '0;
      peer_q     <= '0;
      inc_q      <= '0;
      timer_q    <= '0;
      retry_q    <= '0;
      sent_q     <= 1'b0;
      err_q      <= 1'b0;
      icall_q    <= 1'b0;
      audio_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_type_q  <= tx_type_d;
      tx_addr_q  <= tx_addr_d;
      peer_q     <= peer_d;
      inc_q      <= inc_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      sent_q     <= sent_d;
      err_q      <= err_d;
      icall_q    <= icall_d;
      audio_q    <= audio_d;
    end
  end

endmodule

// File: tb/tb_call_controller.sv
// Bench for call_controller: directed scenarios plus
// random traffic against a message-level reference model.
module tb_call_controller;

  localparam int TO = 20;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = '0;
  logic [7:0] cmd_addr = '0;
  logic       cmd_ready;
  logic       net_tx_valid;
  logic       net_tx_ready = 1'b1;
  logic [2:0] net_tx_type;
  logic [7:0] net_tx_addr;
  logic       net_rx_valid = 1'b0;
  logic [2:0] net_rx_type = '0;
  logic [7:0] net_rx_addr = '0;
  logic       incoming_call;
  logic [7:0] inc_address;
  logic [2:0] call_state;
  logic       audio_en;
  logic       err;

  always #5 clk = ~clk;

  call_controller #(
    .TIMEOUT_CYC(TO),
    .MAX_RETRY(MR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd(cmd),
    .cmd_addr(cmd_addr),
    .cmd_ready(cmd_ready),
    .net_tx_valid(net_tx_valid),
    .net_tx_ready(net_tx_ready),
    .net_tx_type(net_tx_type),
    .net_tx_addr(net_tx_addr),
    .net_rx_valid(net_rx_valid),
    .net_rx_type(net_rx_type),
    .net_rx_addr(net_rx_addr),
    .incoming_call(incoming_call),
    .inc_address(inc_address),
    .call_state(call_state),
    .audio_en(audio_en),
    .err(err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // reference model: phone-level view of the call
  int     m_st = 5;
  bit     m_txv = 0;
  int     m_txt = 0;
  int     m_txa = 0;
  int     m_peer = 0;
  int     m_inc = 0;
  bit     m_err = 0;
  bit     m_sent = 0;
  int     m_att = 0;
  longint m_dl = 0;
  longint mcyc = 0;

  task automatic msend(input int t, input int a);
    m_txv = 1;
    m_txt = t;
    m_txa = a;
  endtask

  task automatic model_step();
    bit free, rq, ar, cok;
    int rt, ra, c, ca;
    mcyc++;
    if (reset) begin
      m_st = 5; m_txv = 0; m_txt = 0; m_txa = 0;
      m_peer = 0; m_inc = 0; m_err = 0;
      m_sent = 0; m_att = 0; m_dl = 0;
      return;
    end
    free = !m_txv;
    rq = net_rx_valid;
    rt = int'(net_rx_type);
    ra = int'(net_rx_addr);
    c = int'(cmd);
    ca = int'(cmd_addr);
    cok = cmd_valid && free && !rq;
    m_err = 0;
    ar = rq && rt == 1 && ra != m_peer && free &&
         (m_st == 1 || m_st == 2 || m_st == 3);
    if (m_txv && net_tx_ready) begin
      m_txv = 0;
      if (m_txt == 1) begin
        m_sent = 1;
        m_dl = mcyc + TO;
      end
    end
    if (ar) msend(3, ra);
    case (m_st)
      5: begin
        if (rq && rt == 0) m_st = 0;
        else if (cok && c == 0) msend(0, ca);
      end
      0: begin
        if (rq && rt == 1) begin
          m_peer = ra; m_inc = ra; m_st = 1;
        end else if (cok && c == 1) begin
          m_peer = ca; msend(1, ca);
          m_att = 1; m_sent = 0; m_st = 2;
        end
      end
      1: begin
        if (rq && ra == m_peer && rt == 4) m_st = 0;
        else if (cok && c == 2) begin
          msend(2, m_peer); m_st = 3;
        end else if (cok && c == 3) begin
          msend(3, m_peer); m_st = 0;
        end
      end
      2: begin
        if (rq && ra == m_peer && rt == 2) m_st = 3;
        else if (rq && ra == m_peer && rt == 3) begin
          m_st = 0; m_err = 1;
        end else if (cok && c == 4) begin
          msend(4, m_peer); m_st = 0;
        end else if (m_sent && mcyc >= m_dl) begin
          if (m_att > MR) begin
            m_st = 0; m_err = 1;
          end else if (free && !ar) begin
            msend(1, m_peer); m_att++; m_sent = 0;
          end
        end
      end
      3: begin
        if (rq && ra == m_peer && rt == 4) m_st = 0;
        else if (cok && c == 4) begin
          msend(4, m_peer); m_st = 0;
        end
      end
      default: m_st = 5;
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  bit     chk_en = 0;
  bit     rec_en = 0;
  longint xq[$];
  int     err_cnt = 0;

  // per-cycle comparison and transfer recording
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("call_state", 64'(call_state), 64'(m_st));
      chk("tx_valid", 64'(net_tx_valid), 64'(m_txv));
      if (m_txv) begin
        chk("tx_type", 64'(net_tx_type), 64'(m_txt));
        chk("tx_addr", 64'(net_tx_addr), 64'(m_txa));
      end
      chk("cmd_ready", 64'(cmd_ready),
          64'(!m_txv && !net_rx_valid));
      chk("incoming_call", 64'(incoming_call),
          64'(m_st == 1));
      chk("inc_address", 64'(inc_address), 64'(m_inc));
      chk("audio_en", 64'(audio_en), 64'(m_st == 3));
      chk("err", 64'(err), 64'(m_err));
    end
    if (rec_en) begin
      if (net_tx_valid && net_tx_ready &&
          net_tx_type == 3'd1)
        xq.push_back(mcyc);
      if (err) err_cnt++;
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_cmd(input int c, input int a);
    cmd_valid = 1'b1;
    cmd = 3'(c);
    cmd_addr = 8'(a);
    cyc_n(1);
    cmd_valid = 1'b0;
  endtask

  task automatic do_rx(input int t, input int a);
    net_rx_valid = 1'b1;
    net_rx_type = 3'(t);
    net_rx_addr = 8'(a);
    cyc_n(1);
    net_rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 3))
      0: return 8'h11;
      1: return 8'h2A;
      2: return 8'h33;
      default: return 8'(m_peer);
    endcase
  endfunction

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    reset = 1'b1;
    cyc_n(2);
    reset = 1'b0;
    chk_en = 1;
    chk("rst_state", 64'(call_state), 64'd5);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_txv", 64'(net_tx_valid), 64'd0);
    chk("rst_type", 64'(net_tx_type), 64'd0);
    chk("rst_addr", 64'(net_tx_addr), 64'd0);
    chk("rst_inc", 64'(inc_address), 64'd0);

    do_cmd(0, 0);
    chk("t026_txv", 64'(net_tx_valid), 64'd1);
    chk("t026_type", 64'(net_tx_type), 64'd0);
    cyc_n(1);
    chk("t026_sent", 64'(net_tx_valid), 64'd0);
    do_rx(0, 8'h55);
    chk("t026_idle", 64'(call_state), 64'd0);

    cmd_valid = 1'b1; cmd = 3'd1; cmd_addr = 8'h2A;
    net_rx_valid = 1'b1; net_rx_type = 3'd4;
    net_rx_addr = 8'h77;
    #1;
    chk("t020_ready", 64'(cmd_ready), 64'd0);
    cyc_n(1);
    cmd_valid = 1'b0; net_rx_valid = 1'b0;
    chk("t020_state", 64'(call_state), 64'd0);
    chk("t020_txv", 64'(net_tx_valid), 64'd0);

    do_cmd(1, 8'h2A);
    chk("t027_out", 64'(call_state), 64'd2);
    chk("t027_type", 64'(net_tx_type), 64'd1);
    chk("t027_addr", 64'(net_tx_addr), 64'h2A);
    cyc_n(3);
    do_rx(2, 8'h2A);
    chk("t027_busy", 64'(call_state), 64'd3);
    chk("t027_audio", 64'(audio_en), 64'd1);
    chk("pin_busy", 64'(m_st), 64'd3);
    do_cmd(4, 0);
    chk("t027_hang", 64'(net_tx_type), 64'd4);
    chk("t027_idle", 64'(call_state), 64'd0);
    cyc_n(1);

    do_cmd(1, 8'h2A);
    cyc_n(TO);
    do_rx(2, 8'h2A);
    chk("t021_busy", 64'(call_state), 64'd3);
    chk("t021_noresend", 64'(net_tx_valid), 64'd0);
    do_cmd(4, 0);
    cyc_n(1);

    xq.delete();
    err_cnt = 0;
    rec_en = 1;
    do_cmd(1, 8'h44);
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      cyc_n(1);
      if (call_state == 3'd0) got = 1;
    end
    chk("t028_done", 64'(got), 64'd1);
    cyc_n(2);
    rec_en = 0;
    chk("t028_reqs", 64'(xq.size()), 64'd4);
    for (int i = 1; i < xq.size(); i++)
      chk("t028_gap", 64'(xq[i] - xq[i-1]), 64'd21);
    chk("t028_err", 64'(err_cnt), 64'd1);
    chk("pin_idle", 64'(m_st), 64'd0);

    do_rx(1, 8'h11);
    chk("t029_inc", 64'(incoming_call), 64'd1);
    chk("t029_addr", 64'(inc_address), 64'h11);
    do_cmd(2, 0);
    chk("t029_type", 64'(net_tx_type), 64'd2);
    chk("t029_to", 64'(net_tx_addr), 64'h11);
    chk("t029_busy", 64'(call_state), 64'd3);
    cyc_n(1);

    do_rx(1, 8'h33);
    chk("t030_txv", 64'(net_tx_valid), 64'd1);
    chk("t030_type", 64'(net_tx_type), 64'd3);
    chk("t030_to", 64'(net_tx_addr), 64'h33);
    chk("t030_busy", 64'(call_state), 64'd3);
    cyc_n(1);

    net_tx_ready = 1'b0;
    do_cmd(4, 0);
    for (int k = 0; k < 2; k++) begin
      chk("t031_txv", 64'(net_tx_valid), 64'd1);
      chk("t031_type", 64'(net_tx_type), 64'd4);
      chk("t031_addr", 64'(net_tx_addr), 64'h11);
      chk("t031_ready", 64'(cmd_ready), 64'd0);
      cyc_n(1);
    end
    reset = 1'b1;
    cyc_n(1);
    reset = 1'b0;
    net_tx_ready = 1'b1;
    chk("t031_drop", 64'(net_tx_valid), 64'd0);
    chk("t031_state", 64'(call_state), 64'd5);
    chk("t031_ready1", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd = 3'($urandom_range(0, 4));
      cmd_addr = pick_addr();
      net_rx_valid = ($urandom_range(0, 4) == 0);
      net_rx_type = 3'($urandom_range(0, 4));
      net_rx_addr = pick_addr();
      net_tx_ready = ($urandom_range(0, 3) != 0);
      cyc_n(1);
    end
    cmd_valid = 1'b0;
    net_rx_valid = 1'b0;
    cyc_n(2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
